bytestream_chan_mux: RTL and testbench

//  Shares one bytestream (bytestream_ft232 bs_* port) between NUM_CH byte clients.
//  TX: round-robin scheduler emits frames = header byte + 1..MAX_BURST payload bytes.
//  RX: parses incoming frames and routes payload to the addressed client.

---
 rtl/bytestream_chan_mux_pkg.sv | 27 ++
 rtl/bytestream_chan_mux_rr_arbiter.sv | 31 +++
 rtl/bytestream_chan_mux.sv | 199 +++++++++++++++++++
 tb/tb_bytestream_chan_mux.sv | 367 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bytestream_chan_mux_pkg.sv
// Shared constants for the bytestream channel mux.
// Header layout, FSM encodings and header builder.
package bytestream_chan_mux_pkg;

  localparam int HDR_LEN_MSB = 7;
  localparam int HDR_LEN_LSB = 4;
  localparam int HDR_CH_MSB  = 3;
  localparam int HDR_CH_LSB  = 0;

  localparam logic [1:0] TX_IDLE = 2'd0;
  localparam logic [1:0] TX_HDR  = 2'd1;
  localparam logic [1:0] TX_DATA = 2'd2;

  localparam logic [1:0] RX_HDR  = 2'd0;
  localparam logic [1:0] RX_DATA = 2'd1;
  localparam logic [1:0] RX_DROP = 2'd2;

  function automatic logic [7:0] mk_hdr(
    input logic [4:0] len,
    input logic [3:0] ch
  );
    logic [4:0] lm1;
    lm1 = len - 5'd1;
    return {lm1[3:0], ch};
  endfunction

endpackage

// File: rtl/bytestream_chan_mux_rr_arbiter.sv
// Round-robin arbiter: first requester at or after ptr,
// searching upward with wrap-around.
module rr_arbiter #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] grant,
  output logic [W-1:0] idx,
  output logic         any
);

  int pos;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    pos   = 0;
    for (int k = 0; k < N; k++) begin
      pos = (int'(ptr) + k) % N;
      if (!any && req[pos]) begin
        any        = 1'b1;
        grant[pos] = 1'b1;
        idx        = W'(pos);
      end
    end
  end

endmodule

// File: rtl/bytestream_chan_mux.sv
// Multiplexes NUM_CH byte clients onto one bytestream
// using {len-1, chan} framed bursts in both directions.
import bytestream_chan_mux_pkg::*;

module bytestream_chan_mux #(
  parameter int NUM_CH    = 4,
  parameter int CH_LOG2   = 2,
  parameter int MAX_BURST = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic [7:0]            bs_data_in,
  output logic                  bs_data_in_valid,
  input  logic                  bs_data_in_consume,
  input  logic [7:0]            bs_data_out,
  input  logic                  bs_data_out_produce,
  input  logic [8*NUM_CH-1:0]   src_data,
  input  logic [5*NUM_CH-1:0]   src_count,
  output logic [NUM_CH-1:0]     src_consume,
  output logic [7:0]            dst_data,
  output logic [NUM_CH-1:0]     dst_produce,
  input  logic [NUM_CH-1:0]     dst_has_space,
  output logic [NUM_CH-1:0]     dst_ovf,
  output logic                  rx_bad_hdr
);

  logic [7:0]         src_byte [NUM_CH];
  logic [4:0]         src_cnt  [NUM_CH];
  logic [NUM_CH-1:0]  req;
  logic [NUM_CH-1:0]  grant_oh;
  logic [NUM_CH-1:0]  chan_oh;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign src_byte[i] = src_data[8*i +: 8];
    assign src_cnt[i]  = src_count[5*i +: 5];
    assign req[i]      = (src_cnt[i] != 5'd0);
  end

  // ---------------- TX scheduler ----------------
  logic [1:0]         tx_state;
  logic [CH_LOG2-1:0] grant_q;
  logic [CH_LOG2-1:0] rr_ptr;
  logic [CH_LOG2-1:0] next_ptr;
  logic [4:0]         len_q;
  logic [4:0]         tx_rem;
  logic [NUM_CH-1:0]  arb_grant;
  logic [CH_LOG2-1:0] arb_idx;
  logic               arb_any;
  logic [4:0]         sel_cnt;
  logic [4:0]         burst_len;
  logic [7:0]         cur_byte;

  rr_arbiter #(
    .N (NUM_CH),
    .W (CH_LOG2)
  ) u_arb (
    .req   (req),
    .ptr   (rr_ptr),
    .grant (arb_grant),
    .idx   (arb_idx),
    .any   (arb_any)
  );

  for (genvar i = 0; i < NUM_CH; i++) begin : g_goh
    assign grant_oh[i] = (grant_q == CH_LOG2'(i));
  end

  always_comb begin
    sel_cnt  = '0;
    cur_byte = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (arb_grant[i]) sel_cnt = sel_cnt | src_cnt[i];
      if (grant_oh[i])  cur_byte = cur_byte | src_byte[i];
    end
  end

  assign burst_len = (sel_cnt > 5'(MAX_BURST))
                   ? 5'(MAX_BURST) : sel_cnt;

  assign next_ptr = (grant_q == CH_LOG2'(NUM_CH - 1))
                  ? '0 : grant_q + 1'b1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_state <= TX_IDLE;
      grant_q  <= '0;
      rr_ptr   <= '0;
      len_q    <= '0;
      tx_rem   <= '0;
    end else begin
      unique case (tx_state)
        TX_IDLE: begin
          if (arb_any) begin
            grant_q  <= arb_idx;
            len_q    <= burst_len;
            tx_state <= TX_HDR;
          end
        end
        TX_HDR: begin
          if (bs_data_in_consume) begin
            tx_rem   <= len_q;
            tx_state <= TX_DATA;
          end
        end
        TX_DATA: begin
          if (bs_data_in_consume) begin
            tx_rem <= tx_rem - 5'd1;
            if (tx_rem == 5'd1) begin
              tx_state <= TX_IDLE;
              rr_ptr   <= next_ptr;
            end
          end
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

  // Client pop is tied straight to the bytestream accept.
  always_comb begin
    bs_data_in       = '0;
    bs_data_in_valid = 1'b0;
    src_consume      = '0;
    unique case (tx_state)
      TX_HDR: begin
        bs_data_in       = mk_hdr(len_q, 4'(grant_q));
        bs_data_in_valid = 1'b1;
      end
      TX_DATA: begin
        bs_data_in       = cur_byte;
        bs_data_in_valid = 1'b1;
        if (bs_data_in_consume) src_consume = grant_oh;
      end
      default: ;
    endcase
  end

  // ---------------- RX parser ----------------
  logic [1:0] rx_state;
  logic [3:0] rx_chan;
  logic [4:0] rx_rem;
  logic [3:0] in_ch;
  logic [3:0] in_len;
  logic       hdr_bad;
  logic       space_ok;

  assign in_ch  = bs_data_out[HDR_CH_MSB:HDR_CH_LSB];
  assign in_len = bs_data_out[HDR_LEN_MSB:HDR_LEN_LSB];
  assign hdr_bad = (int'(in_ch) >= NUM_CH);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_coh
    assign chan_oh[i] = (rx_chan == 4'(i));
  end

  assign space_ok = |(dst_has_space & chan_oh);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_state    <= RX_HDR;
      rx_chan     <= '0;
      rx_rem      <= '0;
      dst_data    <= '0;
      dst_produce <= '0;
      dst_ovf     <= '0;
      rx_bad_hdr  <= 1'b0;
    end else begin
      dst_produce <= '0;
      dst_ovf     <= '0;
      rx_bad_hdr  <= 1'b0;
      if (bs_data_out_produce) begin
        unique case (rx_state)
          RX_HDR: begin
            rx_chan <= in_ch;
            rx_rem  <= {1'b0, in_len} + 5'd1;
            if (hdr_bad) begin
              rx_bad_hdr <= 1'b1;
              rx_state   <= RX_DROP;
            end else begin
              rx_state <= RX_DATA;
            end
          end
          RX_DATA: begin
            dst_data <= bs_data_out;
            if (space_ok) dst_produce <= chan_oh;
            else          dst_ovf     <= chan_oh;
            rx_rem <= rx_rem - 5'd1;
            if (rx_rem == 5'd1) rx_state <= RX_HDR;
          end
          RX_DROP: begin
            rx_rem <= rx_rem - 5'd1;
            if (rx_rem == 5'd1) rx_state <= RX_HDR;
          end
          default: rx_state <= RX_HDR;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_bytestream_chan_mux.sv
// Scoreboard bench for bytestream_chan_mux: modelled client
// FIFOs and bytestream sink on TX, directed frames on RX.
module tb_bytestream_chan_mux;

  localparam int NUM_CH = 4;

  logic                 clk = 1'b0;
  logic                 reset = 1'b0;
  logic [7:0]           bs_data_in;
  logic                 bs_data_in_valid;
  logic                 bs_data_in_consume;
  logic [7:0]           bs_data_out;
  logic                 bs_data_out_produce;
  logic [8*NUM_CH-1:0]  src_data;
  logic [5*NUM_CH-1:0]  src_count;
  logic [NUM_CH-1:0]    src_consume;
  logic [7:0]           dst_data;
  logic [NUM_CH-1:0]    dst_produce;
  logic [NUM_CH-1:0]    dst_has_space;
  logic [NUM_CH-1:0]    dst_ovf;
  logic                 rx_bad_hdr;

  always #5 clk = ~clk;

  bytestream_chan_mux #(
    .NUM_CH    (NUM_CH),
    .CH_LOG2   (2),
    .MAX_BURST (16)
  ) dut (
    .clk                 (clk),
    .reset               (reset),
    .bs_data_in          (bs_data_in),
    .bs_data_in_valid    (bs_data_in_valid),
    .bs_data_in_consume  (bs_data_in_consume),
    .bs_data_out         (bs_data_out),
    .bs_data_out_produce (bs_data_out_produce),
    .src_data            (src_data),
    .src_count           (src_count),
    .src_consume         (src_consume),
    .dst_data            (dst_data),
    .dst_produce         (dst_produce),
    .dst_has_space       (dst_has_space),
    .dst_ovf             (dst_ovf),
    .rx_bad_hdr          (rx_bad_hdr)
  );

  typedef struct {
    logic [NUM_CH-1:0] prod;
    logic [NUM_CH-1:0] ovf;
    logic [7:0]        data;
  } rx_exp_t;

  logic [7:0]  exp_tx [$];
  rx_exp_t     exp_rx [$];
  logic [7:0]  cq [NUM_CH][$];
  int          exp_bad = 0;
  int          pop_cnt [NUM_CH];
  int          budget = 1000000;
  int          n_vec = 0;
  int          n_err = 0;
  logic [NUM_CH-1:0] pop_mask;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  task automatic fail_now(input string name,
                          input logic [31:0] act);
    n_vec++;
    n_err++;
    $display("FAIL %s: got %0h expected nothing",
             name, act);
  endtask

  task automatic refresh();
    for (int i = 0; i < NUM_CH; i++) begin
      int sz;
      sz = cq[i].size();
      src_count[5*i +: 5] = (sz > 31) ? 5'd31 : 5'(sz);
      src_data[8*i +: 8]  = (sz > 0) ? cq[i][0] : 8'h00;
    end
  endtask

  // bytestream sink + client TX FIFO model
  initial begin
    bs_data_in_consume = 1'b0;
    src_data  = '0;
    src_count = '0;
    pop_mask  = '0;
    for (int i = 0; i < NUM_CH; i++) pop_cnt[i] = 0;
    forever begin
      @(negedge clk);
      if (reset && bs_data_in_valid && budget > 0) begin
        if (exp_tx.size() == 0)
          fail_now("tx_unexpected", 32'(bs_data_in));
        else
          check("tx_byte", 32'(bs_data_in),
                32'(exp_tx.pop_front()));
        bs_data_in_consume = 1'b1;
        budget--;
      end else begin
        bs_data_in_consume = 1'b0;
      end
      #1;
      pop_mask = src_consume;
      if (pop_mask != '0 && !bs_data_in_consume)
        fail_now("pop_without_consume", 32'(pop_mask));
      @(posedge clk);
      #1;
      for (int i = 0; i < NUM_CH; i++) begin
        if (pop_mask[i] && cq[i].size() > 0) begin
          void'(cq[i].pop_front());
          pop_cnt[i]++;
        end
      end
      refresh();
    end
  end

  // RX monitor
  initial begin
    rx_exp_t e;
    forever begin
      @(negedge clk);
      if (dst_produce != '0 || dst_ovf != '0) begin
        if (exp_rx.size() == 0) begin
          fail_now("rx_unexpected",
                   32'({dst_produce, dst_ovf}));
        end else begin
          e = exp_rx.pop_front();
          check("dst_produce", 32'(dst_produce), 32'(e.prod));
          check("dst_ovf", 32'(dst_ovf), 32'(e.ovf));
          if (e.prod != '0)
            check("dst_data", 32'(dst_data), 32'(e.data));
        end
      end
      if (rx_bad_hdr) begin
        if (exp_bad > 0) begin
          n_vec++;
          exp_bad--;
        end else begin
          fail_now("rx_bad_hdr_unexpected", 32'(1));
        end
      end
    end
  end

  task automatic rx_byte(input logic [7:0] b);
    @(negedge clk);
    bs_data_out = b;
    bs_data_out_produce = 1'b1;
  endtask

  task automatic rx_end();
    @(negedge clk);
    bs_data_out_produce = 1'b0;
  endtask

  task automatic exp_push(input int ch, input logic [7:0] d);
    rx_exp_t e;
    e.prod = '0;
    e.ovf  = '0;
    e.prod[ch] = 1'b1;
    e.data = d;
    exp_rx.push_back(e);
  endtask

  task automatic exp_drop(input int ch);
    rx_exp_t e;
    e.prod = '0;
    e.ovf  = '0;
    e.ovf[ch] = 1'b1;
    e.data = 8'h00;
    exp_rx.push_back(e);
  endtask

  task automatic drain(input string name);
    int t;
    t = 0;
    while (t < 400 && (exp_tx.size() != 0 ||
           exp_rx.size() != 0 || exp_bad != 0)) begin
      @(negedge clk);
      t++;
    end
    repeat (4) @(negedge clk);
    check({"drain_", name},
          32'(exp_tx.size() + exp_rx.size() + exp_bad), 0);
  endtask

  task automatic clr_pops();
    for (int i = 0; i < NUM_CH; i++) pop_cnt[i] = 0;
  endtask

  initial begin
    int t;
    bs_data_out = 8'h00;
    bs_data_out_produce = 1'b0;
    dst_has_space = '1;

    // reset values
    repeat (3) @(negedge clk);
    check("rst_valid", 32'(bs_data_in_valid), 0);
    check("rst_bs_data", 32'(bs_data_in), 0);
    check("rst_src_consume", 32'(src_consume), 0);
    check("rst_dst_produce", 32'(dst_produce), 0);
    check("rst_dst_ovf", 32'(dst_ovf), 0);
    check("rst_bad_hdr", 32'(rx_bad_hdr), 0);
    check("rst_dst_data", 32'(dst_data), 0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // 1: ch0, 3 bytes
    clr_pops();
    cq[0].push_back(8'h11);
    cq[0].push_back(8'h22);
    cq[0].push_back(8'h33);
    exp_tx.push_back(8'h20);
    exp_tx.push_back(8'h11);
    exp_tx.push_back(8'h22);
    exp_tx.push_back(8'h33);
    drain("t1");
    check("t1_pops_ch0", 32'(pop_cnt[0]), 3);

    // 2: ch1, 20 bytes split 16 + 4
    clr_pops();
    for (int i = 0; i < 20; i++) cq[1].push_back(8'(8'h40 + i));
    exp_tx.push_back(8'hF1);
    for (int i = 0; i < 16; i++) exp_tx.push_back(8'(8'h40 + i));
    exp_tx.push_back(8'h31);
    for (int i = 16; i < 20; i++) exp_tx.push_back(8'(8'h40 + i));
    drain("t2");
    check("t2_pops_ch1", 32'(pop_cnt[1]), 20);

    // 3: ch0 + ch2, rr ptr now 2 -> ch2, wrap to ch0
    clr_pops();
    cq[0].push_back(8'hA0);
    cq[0].push_back(8'hA1);
    cq[2].push_back(8'hC0);
    cq[2].push_back(8'hC1);
    exp_tx.push_back(8'h12);
    exp_tx.push_back(8'hC0);
    exp_tx.push_back(8'hC1);
    exp_tx.push_back(8'h10);
    exp_tx.push_back(8'hA0);
    exp_tx.push_back(8'hA1);
    drain("t3a");
    cq[0].push_back(8'hB0);
    cq[2].push_back(8'hD0);
    exp_tx.push_back(8'h02);
    exp_tx.push_back(8'hD0);
    exp_tx.push_back(8'h00);
    exp_tx.push_back(8'hB0);
    drain("t3b");
    check("t3_pops_ch0", 32'(pop_cnt[0]), 3);
    check("t3_pops_ch2", 32'(pop_cnt[2]), 3);

    // 4: RX to ch2, back-to-back
    exp_push(2, 8'hAA);
    exp_push(2, 8'hBB);
    rx_byte(8'h12);
    rx_byte(8'hAA);
    rx_byte(8'hBB);
    rx_end();
    drain("t4");

    // 5: bad header, overflow, long drop, 16-byte frame
    exp_bad = 1;
    rx_byte(8'h05);
    rx_byte(8'h77);
    rx_end();
    drain("t5_bad");
    dst_has_space = 4'b0111;
    exp_drop(3);
    rx_byte(8'h03);
    rx_byte(8'h5A);
    rx_end();
    drain("t5_ovf");
    dst_has_space = '1;
    exp_push(3, 8'hC1);
    exp_push(3, 8'hC2);
    rx_byte(8'h13);
    rx_byte(8'hC1);
    rx_byte(8'hC2);
    rx_end();
    drain("t5_ch3");
    exp_bad = 1;
    exp_push(1, 8'hAB);
    rx_byte(8'hF7);
    for (int i = 0; i < 16; i++) rx_byte(8'h01);
    rx_byte(8'h01);
    rx_byte(8'hAB);
    rx_end();
    drain("t5_drop16");
    for (int i = 0; i < 16; i++) exp_push(0, 8'(8'h80 + i));
    rx_byte(8'hF0);
    for (int i = 0; i < 16; i++) rx_byte(8'(8'h80 + i));
    rx_end();
    drain("t5_rx16");

    // 7: TX and RX at the same time
    clr_pops();
    cq[3].push_back(8'hE0);
    cq[3].push_back(8'hE1);
    cq[3].push_back(8'hE2);
    exp_tx.push_back(8'h23);
    exp_tx.push_back(8'hE0);
    exp_tx.push_back(8'hE1);
    exp_tx.push_back(8'hE2);
    exp_push(1, 8'h5B);
    exp_push(1, 8'h5C);
    rx_byte(8'h11);
    rx_byte(8'h5B);
    rx_byte(8'h5C);
    rx_end();
    drain("t7");
    check("t7_pops_ch3", 32'(pop_cnt[3]), 3);

    // 6: reset in the middle of TX_DATA
    budget = 2;
    for (int i = 1; i <= 5; i++) cq[0].push_back(8'(i));
    exp_tx.push_back(8'h40);
    exp_tx.push_back(8'h01);
    t = 0;
    while (budget > 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("t6_budget_used", 32'(budget), 0);
    repeat (2) @(negedge clk);
    check("t6_stall_valid", 32'(bs_data_in_valid), 1);
    check("t6_stall_data", 32'(bs_data_in), 32'(8'h02));
    #2;
    reset = 1'b0;
    #1;
    check("t6_rst_valid", 32'(bs_data_in_valid), 0);
    check("t6_rst_data", 32'(bs_data_in), 0);
    check("t6_rst_consume", 32'(src_consume), 0);
    cq[0].delete();
    exp_tx.delete();
    budget = 1000000;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    cq[0].push_back(8'h77);
    exp_tx.push_back(8'h00);
    exp_tx.push_back(8'h77);
    drain("t6");

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
